// File: rtl/load_unit.sv
// load_unit: multi-cycle MIPS-I load engine (LB/LBU/LH/LHU/LW/LWL/LWR).
// Latches the effective address on start, issues one word-aligned read with
// a waitrequest handshake, then aligns/extends the returned word and presents
// it to the register-file load write port for exactly one cycle.
module load_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  opcode,
   input  logic [31:0] base,
   input  logic [15:0] offset,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        write_enable_ld,
   output logic [31:0] write_data_ld,
   output logic [3:0]  byteenable_ld
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LWL = 6'h22;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_LWR = 6'h26;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WB   = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   // Transaction context; data-only registers, qualified by state everywhere
   logic [5:0]         r_op;
   logic [31:0]        r_ea;
   logic [31:0]        r_word;

   logic signed [31:0] w_offset_sext;
   logic [31:0]        w_ea_in;
   logic               w_fault_in;
   logic               w_accept;
   logic               w_handshake;
   logic [1:0]         w_lane;

   // Misaligned halfword/word accesses and unknown opcodes fault at latch time
   function automatic logic f_fault(input logic [5:0] op, input logic [1:0] lane);
      logic flt;
      flt = 1'b0;
      case (op)
         OP_LB, OP_LBU, OP_LWL, OP_LWR: flt = 1'b0;
         OP_LH, OP_LHU:                 flt = lane[0];
         OP_LW:                         flt = (lane != 2'd0);
         default:                       flt = 1'b1;
      endcase
      return flt;
   endfunction

   // Byte lanes requested on the memory bus
   function automatic logic [3:0] f_mem_be(input logic [5:0] op, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b1111;
      case (op)
         OP_LB, OP_LBU: be = 4'b0001 << lane;
         OP_LH, OP_LHU: be = lane[1] ? 4'b1100 : 4'b0011;
         default:       be = 4'b1111;
      endcase
      return be;
   endfunction

   // Register byte lanes written; LWL/LWR merge only part of rt
   function automatic logic [3:0] f_reg_be(input logic [5:0] op, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b1111;
      case (op)
         OP_LWL: be = 4'b1111 << (~lane);
         OP_LWR: be = 4'b1111 >> lane;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Align the returned word into register position, with sign/zero extension
   function automatic logic [31:0] f_align(input logic [5:0] op, input logic [1:0] lane,
                                           input logic [31:0] w);
      logic [31:0] sh_byte;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] d;
      sh_byte = w >> {lane, 3'b000};
      b       = sh_byte[7:0];
      h       = lane[1] ? w[31:16] : w[15:0];
      d       = 32'd0;
      case (op)
         OP_LB:  d = {{24{b[7]}}, b};
         OP_LBU: d = {24'd0, b};
         OP_LH:  d = {{16{h[15]}}, h};
         OP_LHU: d = {16'd0, h};
         OP_LW:  d = w;
         OP_LWL: d = w << {~lane, 3'b000};
         OP_LWR: d = w >> {lane, 3'b000};
         default: d = 32'd0;
      endcase
      return d;
   endfunction

   // Effective address wraps modulo 2^32; no overflow trap for loads
   assign w_offset_sext = {{16{offset[15]}}, offset};
   assign w_ea_in       = base + w_offset_sext;
   assign w_fault_in    = f_fault(opcode, w_ea_in[1:0]);
   assign w_accept      = (r_state == S_IDLE) && start;
   assign w_handshake   = (r_state == S_REQ) && !mem_waitrequest;
   assign w_lane        = r_ea[1:0];

   // State register; async reset kills any in-flight request immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latch opcode/address on accept and the read word on the handshake edge
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op <= opcode;
         r_ea <= w_ea_in;
      end
      if (w_handshake) begin
         r_word <= mem_readdata;
      end
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      w_state_nxt     = r_state;
      mem_read        = 1'b0;
      mem_address     = 32'd0;
      mem_byteenable  = 4'b0000;
      busy            = 1'b1;
      done            = 1'b0;
      fault           = 1'b0;
      write_enable_ld = 1'b0;
      write_data_ld   = 32'd0;
      byteenable_ld   = 4'b0000;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_state_nxt = w_fault_in ? S_ERR : S_REQ;
            end
         end
         S_REQ: begin
            mem_read       = 1'b1;
            mem_address    = {r_ea[31:2], 2'b00};
            mem_byteenable = f_mem_be(r_op, w_lane);
            if (!mem_waitrequest) begin
               w_state_nxt = S_WB;
            end
         end
         S_WB: begin
            done            = 1'b1;
            write_enable_ld = 1'b1;
            write_data_ld   = f_align(r_op, w_lane, r_word);
            byteenable_ld   = f_reg_be(r_op, w_lane);
            w_state_nxt     = S_IDLE;
         end
         S_ERR: begin
            done        = 1'b1;
            fault       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed vectors with hand-computed expectations for load_unit.
module tb_load_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  opcode;
   logic [31:0] base;
   logic [15:0] offset;
   logic [31:0] mem_address;
   logic        mem_read;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest;
   logic        busy;
   logic        done;
   logic        fault;
   logic        write_enable_ld;
   logic [31:0] write_data_ld;
   logic [3:0]  byteenable_ld;

   int n_checks;
   int n_errors;

   load_unit dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .opcode          (opcode),
      .base            (base),
      .offset          (offset),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_byteenable  (mem_byteenable),
      .mem_readdata    (mem_readdata),
      .mem_waitrequest (mem_waitrequest),
      .busy            (busy),
      .done            (done),
      .fault           (fault),
      .write_enable_ld (write_enable_ld),
      .write_data_ld   (write_data_ld),
      .byteenable_ld   (byteenable_ld)
   );

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " busy"}, {31'd0, busy}, 32'd0);
      chk({tag, " done"}, {31'd0, done}, 32'd0);
      chk({tag, " we"}, {31'd0, write_enable_ld}, 32'd0);
      chk({tag, " mem_read"}, {31'd0, mem_read}, 32'd0);
      chk({tag, " wdata"}, write_data_ld, 32'd0);
   endtask

   // One load: start at edge 0, REQ for waits+1 cycles, WB next, then IDLE
   task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] b,
                          input logic [15:0] off, input logic [31:0] w, input int waits,
                          input bit pulse, input logic [31:0] exp_addr,
                          input logic [3:0] exp_mbe, input logic [31:0] exp_data,
                          input logic [3:0] exp_be);
      start        = 1'b1;
      opcode       = op;
      base         = b;
      offset       = off;
      mem_readdata = ~w;
      step();
      start  = 1'b0;
      opcode = 6'h00;
      base   = 32'h0;
      offset = 16'h0;
      for (int i = 0; i <= waits; i++) begin
         mem_waitrequest = (i < waits);
         mem_readdata    = (i < waits) ? ~w : w;
         #1;
         chk({tag, " req mem_read"}, {31'd0, mem_read}, 32'd1);
         chk({tag, " req addr"}, mem_address, exp_addr);
         chk({tag, " req mbe"}, {28'd0, mem_byteenable}, {28'd0, exp_mbe});
         chk({tag, " req busy"}, {31'd0, busy}, 32'd1);
         chk({tag, " req done"}, {31'd0, done}, 32'd0);
         chk({tag, " req we"}, {31'd0, write_enable_ld}, 32'd0);
         if (pulse && i == 1) begin
            start  = 1'b1;
            opcode = 6'h20;
            base   = 32'h5555_0001;
         end else begin
            start  = 1'b0;
            opcode = 6'h00;
            base   = 32'h0;
         end
         step();
      end
      start           = 1'b0;
      mem_waitrequest = 1'b0;
      mem_readdata    = 32'hA5A5_5A5A;
      #1;
      chk({tag, " wb done"}, {31'd0, done}, 32'd1);
      chk({tag, " wb fault"}, {31'd0, fault}, 32'd0);
      chk({tag, " wb we"}, {31'd0, write_enable_ld}, 32'd1);
      chk({tag, " wb data"}, write_data_ld, exp_data);
      chk({tag, " wb be"}, {28'd0, byteenable_ld}, {28'd0, exp_be});
      chk({tag, " wb mem_read"}, {31'd0, mem_read}, 32'd0);
      step();
      chk_idle({tag, " after"});
   endtask

   // Faulting request: ERR in cycle 1, no bus access, no write
   task automatic do_fault(input string tag, input logic [5:0] op, input logic [31:0] b,
                           input logic [15:0] off);
      start  = 1'b1;
      opcode = op;
      base   = b;
      offset = off;
      step();
      start = 1'b0;
      chk({tag, " err done"}, {31'd0, done}, 32'd1);
      chk({tag, " err fault"}, {31'd0, fault}, 32'd1);
      chk({tag, " err busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " err we"}, {31'd0, write_enable_ld}, 32'd0);
      chk({tag, " err mem_read"}, {31'd0, mem_read}, 32'd0);
      step();
      chk_idle({tag, " after"});
      chk({tag, " after fault"}, {31'd0, fault}, 32'd0);
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst             = 1'b1;
      start           = 1'b0;
      opcode          = 6'h00;
      base            = 32'h0;
      offset          = 16'h0;
      mem_readdata    = 32'h0;
      mem_waitrequest = 1'b0;
      #12;
      chk_idle("reset");
      chk("reset addr", mem_address, 32'd0);
      chk("reset mbe", {28'd0, mem_byteenable}, 32'd0);
      chk("reset fault", {31'd0, fault}, 32'd0);
      chk("reset be_ld", {28'd0, byteenable_ld}, 32'd0);
      step();
      rst = 1'b0;
      step();
      chk_idle("post-reset");

      do_load("LW",     6'h23, 32'h0000_1000, 16'h0004, 32'hDEAD_BEEF, 0, 1'b0,
              32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 4'b1111);
      do_load("LB l3",  6'h20, 32'h0000_2000, 16'h0003, 32'h80FF_7F01, 0, 1'b0,
              32'h0000_2000, 4'b1000, 32'hFFFF_FF80, 4'b1111);
      do_load("LBU l3", 6'h24, 32'h0000_2000, 16'h0003, 32'h80FF_7F01, 0, 1'b0,
              32'h0000_2000, 4'b1000, 32'h0000_0080, 4'b1111);
      do_load("LB l1",  6'h20, 32'h0000_3000, 16'h0001, 32'h80FF_7F01, 0, 1'b0,
              32'h0000_3000, 4'b0010, 32'h0000_007F, 4'b1111);
      do_load("LBU l2", 6'h24, 32'h0000_3000, 16'h0002, 32'h80FF_7F01, 0, 1'b0,
              32'h0000_3000, 4'b0100, 32'h0000_00FF, 4'b1111);
      do_load("LH neg", 6'h21, 32'h0000_0000, 16'hFFFE, 32'h9ABC_1234, 0, 1'b0,
              32'hFFFF_FFFC, 4'b1100, 32'hFFFF_9ABC, 4'b1111);
      do_load("LHU hi", 6'h25, 32'h0000_0000, 16'hFFFE, 32'h9ABC_1234, 0, 1'b0,
              32'hFFFF_FFFC, 4'b1100, 32'h0000_9ABC, 4'b1111);
      do_load("LH lo",  6'h21, 32'h0000_0100, 16'h0000, 32'h9ABC_1234, 0, 1'b0,
              32'h0000_0100, 4'b0011, 32'h0000_1234, 4'b1111);
      do_load("LW wrap", 6'h23, 32'h0000_0010, 16'hFFF0, 32'h0BAD_F00D, 0, 1'b0,
              32'h0000_0000, 4'b1111, 32'h0BAD_F00D, 4'b1111);

      do_load("LWL l0", 6'h22, 32'h0000_0800, 16'h0000, 32'h4433_2211, 0, 1'b0,
              32'h0000_0800, 4'b1111, 32'h1100_0000, 4'b1000);
      do_load("LWL l1", 6'h22, 32'h0000_0800, 16'h0001, 32'h4433_2211, 0, 1'b0,
              32'h0000_0800, 4'b1111, 32'h2211_0000, 4'b1100);
      do_load("LWL l2", 6'h22, 32'h0000_0800, 16'h0002, 32'h4433_2211, 0, 1'b0,
              32'h0000_0800, 4'b1111, 32'h3322_1100, 4'b1110);
      do_load("LWL l3", 6'h22, 32'h0000_0800, 16'h0003, 32'h4433_2211, 0, 1'b0,
              32'h0000_0800, 4'b1111, 32'h4433_2211, 4'b1111);
      do_load("LWR l0", 6'h26, 32'h0000_0800, 16'h0000, 32'h4433_2211, 0, 1'b0,
              32'h0000_0800, 4'b1111, 32'h4433_2211, 4'b1111);
      do_load("LWR l1", 6'h26, 32'h0000_0800, 16'h0001, 32'h4433_2211, 0, 1'b0,
              32'h0000_0800, 4'b1111, 32'h0044_3322, 4'b0111);
      do_load("LWR l2", 6'h26, 32'h0000_0800, 16'h0002, 32'h4433_2211, 0, 1'b0,
              32'h0000_0800, 4'b1111, 32'h0000_4433, 4'b0011);
      do_load("LWR l3", 6'h26, 32'h0000_0800, 16'h0003, 32'h4433_2211, 0, 1'b0,
              32'h0000_0800, 4'b1111, 32'h0000_0044, 4'b0001);

      do_load("LW wait3", 6'h23, 32'h0000_4000, 16'h0008, 32'h1234_5678, 3, 1'b1,
              32'h0000_4008, 4'b1111, 32'h1234_5678, 4'b1111);

      do_fault("LW misal", 6'h23, 32'h0000_1000, 16'h0002);
      do_fault("bad op",   6'h27, 32'h0000_1000, 16'h0000);
      do_fault("LH misal", 6'h21, 32'h0000_1000, 16'h0001);
      do_fault("LHU misal", 6'h25, 32'h0000_1000, 16'h0003);

      // Reset asserted while the request is stalled on the bus
      start           = 1'b1;
      opcode          = 6'h23;
      base            = 32'h0000_6000;
      offset          = 16'h0000;
      mem_waitrequest = 1'b1;
      step();
      start = 1'b0;
      chk("rst pre mem_read", {31'd0, mem_read}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst addr", mem_address, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst we", {31'd0, write_enable_ld}, 32'd0);
      #1;
      rst             = 1'b0;
      mem_waitrequest = 1'b0;
      step();
      chk_idle("rst after");
      step();
      chk_idle("rst after2");

      // Unit still works after the mid-transaction reset
      do_load("LW post-rst", 6'h23, 32'h0000_6000, 16'h0004, 32'hCAFE_F00D, 0, 1'b0,
              32'h0000_6004, 4'b1111, 32'hCAFE_F00D, 4'b1111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/load_unit.md
# load_unit

Multi-cycle MIPS load engine sitting directly upstream of the register file's load write port. It accepts one load instruction (LB, LBU, LH, LHU, LW, LWL, LWR), computes the effective address, and performs one word-aligned read on the data-memory bus with a waitrequest handshake. It then aligns and extends the returned word and drives `write_enable_ld` / `write_data_ld` / `byteenable_ld` for exactly one cycle. The register file writes the result into `addr_rt`; the decoder holds `addr_rt` stable from `start` until `done`.

## Interface
- No parameters; all widths are fixed by the MIPS-I ISA.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset is asynchronous and active-high.
- `start` in 1: request a load; sampled only in IDLE.
- `opcode` in 6: 0x20 LB, 0x21 LH, 0x22 LWL, 0x23 LW, 0x24 LBU, 0x25 LHU, 0x26 LWR.
- `base` in 32: rs value.
- `offset` in 16: immediate, sign-extended.
- `mem_address` out 32: word address, low two bits always 0.
- `mem_read` out 1: read strobe.
- `mem_byteenable` out 4: byte lanes requested.
- `mem_readdata` in 32: read data, little-endian lanes.
- `mem_waitrequest` in 1: memory stall.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: one-cycle pulse for a misaligned access or an unsupported opcode; coincides with `done`.
- `write_enable_ld` out 1: register-file write strobe.
- `write_data_ld` out 32: aligned data.
- `byteenable_ld` out 4: register byte lanes to write.

## Operation
- On `start` in IDLE, the block latches `opcode` and `ea = base + sext(offset)`, computed modulo 2^32 with no overflow trap.
  - `lane = ea[1:0]`; `w = mem_readdata`.
- Alignment check at latch time:
  - LH or LHU with `lane[0]=1` → fault.
  - LW with `lane != 0` → fault.
  - Any opcode outside the supported list → fault.
  - LB, LBU, LWL and LWR never fault.
- FSM states: IDLE, REQ, WB, ERR.
  - IDLE → REQ on `start` with no fault.
  - IDLE → ERR on `start` with a fault.
  - REQ → WB on the edge where `mem_read=1` and `mem_waitrequest=0`; `w` is captured on that edge.
  - WB → IDLE and ERR → IDLE unconditionally.
- REQ outputs: `mem_read=1`, `mem_address={ea[31:2],2'b00}`.
  - `mem_byteenable` is `1<<lane` for LB/LBU, `0011` or `1100` for LH/LHU, and `1111` otherwise.
  - These outputs are held constant while `mem_waitrequest=1`.
- WB outputs: `write_enable_ld=1` and `done=1`.
  - LB: data `sext(w[8*lane+:8])`, byteenable `1111`.
  - LBU: data `zext(w[8*lane+:8])`, byteenable `1111`.
  - LH: data `sext(w[16*lane[1]+:16])`, byteenable `1111`.
  - LHU: data `zext(w[16*lane[1]+:16])`, byteenable `1111`.
  - LW: data `w`, byteenable `1111`.
  - LWL: data `w << 8*(3-lane)`; byteenable by lane 0/1/2/3 = `1000`/`1100`/`1110`/`1111`.
  - LWR: data `w >> 8*lane`; byteenable by lane 0/1/2/3 = `1111`/`0111`/`0011`/`0001`.
- ERR outputs: `done=1`, `fault=1`, `write_enable_ld=0`. No bus access is issued.
- `start` while `busy` is ignored and does not queue.
- Outside WB, `write_enable_ld=0`, `write_data_ld=0`, `byteenable_ld=0000`.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Reset values:
  - state IDLE.
  - `mem_read=0`, `mem_address=0`, `mem_byteenable=0`.
  - `busy=0`, `done=0`, `fault=0`.
  - `write_enable_ld=0`, `write_data_ld=0`, `byteenable_ld=0`.
- Latency: with `start` at edge 0 and zero wait states, REQ occupies cycle 1 and WB occupies cycle 2. Each cycle of waitrequest adds one cycle.
- Fault latency: ERR occupies cycle 1.
- Throughput: a new `start` is accepted in the cycle after WB/ERR, i.e. when back in IDLE.
- `rst` mid-transaction drops `mem_read` and `write_enable_ld` immediately (asynchronously); no partial write occurs. The next access begins only after `rst` deasserts and a fresh `start` arrives.
- `mem_readdata` is ignored outside the REQ handshake edge.

## Test plan
- LW, base 0x1000, offset 0x0004, w=0xDEADBEEF, no wait → `mem_address=0x1004`, `be=1111`; WB at cycle 2 with data 0xDEADBEEF, `byteenable_ld=1111`.
- LB and LBU, ea=0x2003, w=0x80FF7F01 → LB 0xFFFFFF80, LBU 0x00000080; `mem_byteenable=1000`.
- LH, base 0x0, offset 0xFFFE (ea=0xFFFFFFFE), w=0x9ABC1234 → `mem_address=0xFFFFFFFC`, data 0xFFFF9ABC.
- LWL at lanes 0–3 and LWR at lanes 0–3, w=0x44332211 → LWL lane1 0x22110000/`1100`; LWR lane2 0x00004433/`0011`; remaining lanes per Operation.
- LW with 3 cycles of waitrequest → `mem_read` and address stable for 4 cycles, `done` at cycle 5; `start` pulsed during REQ is ignored.
- LW at ea=0x1002, then opcode 0x27 → each gives `fault` and `done` at cycle 1, `mem_read` never high, no write. Separately, `rst` asserted during REQ → all outputs zero within the same cycle.
